bus_sequencer: RTL and testbench

//  Bus initiator for the register bank: fetches instruction bytes from program ROM and sequences

---
 rtl/bus_sequencer.sv | 138 +++++++++++++
 tb/tb_bus_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Bus initiator: fetches program bytes from ROM, sequences bank assert/trigger strobes and drives immediates on dbus.
// Latency: MOV reg 3 cycles, MOV imm 4, JMP 2, NOP/reserved 1; run only stalls at instruction fetch.
module bus_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       resetBar,
  input  logic       run,
  input  logic [7:0] rom_data,
  output logic [7:0] rom_addr,
  inout  wire  [7:0] dbus,
  output logic       assertBarA,
  output logic       assertBarX,
  output logic       triggerA,
  output logic       triggerB,
  output logic       triggerX,
  output logic       triggerQ,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_IMM,
    S_DRIVE,
    S_LATCH,
    S_HALT
  } state_t;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [1:0] SRC_A   = 2'd0;
  localparam logic [1:0] SRC_X   = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic       bar_a_q, bar_a_d;
  logic       bar_x_q, bar_x_d;
  logic       drive_q, drive_d;
  logic [3:0] trig_q, trig_d;
  logic       bus_phase;

  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      imm_q   <= 8'h00;
      bar_a_q <= 1'b1;
      bar_x_q <= 1'b1;
      drive_q <= 1'b0;
      trig_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      imm_q   <= imm_d;
      bar_a_q <= bar_a_d;
      bar_x_q <= bar_x_d;
      drive_q <= drive_d;
      trig_q  <= trig_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    bar_a_d   = 1'b1;
    bar_x_d   = 1'b1;
    drive_d   = 1'b0;
    trig_d    = 4'b0000;
    bus_phase = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_d = rom_data;
          pc_d = pc_q + 8'd1;
          case (rom_data[7:6])
            OP_MOV: begin
              case (rom_data[5:4])
                SRC_A, SRC_X: state_d = S_DRIVE;
                SRC_IMM:      state_d = S_IMM;
                default:      state_d = S_FETCH;
              endcase
            end
            OP_JMP:  state_d = S_IMM;
            OP_NOP:  state_d = S_FETCH;
            OP_HALT: state_d = S_HALT;
          endcase
        end
      end
      S_IMM: begin
        imm_d = rom_data;
        if (ir_q[7:6] == OP_JMP) begin
          pc_d    = rom_data;
          state_d = S_FETCH;
        end else begin
          pc_d    = pc_q + 8'd1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: state_d = S_LATCH;
      S_LATCH: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Strobes are registered from the next state so they change only on clock edges.
    bus_phase = (state_d == S_DRIVE) || (state_d == S_LATCH);
    if (bus_phase) begin
      bar_a_d = (ir_d[5:4] != SRC_A);
      bar_x_d = (ir_d[5:4] != SRC_X);
      drive_d = (ir_d[5:4] == SRC_IMM);
    end
    if (state_d == S_LATCH) begin
      trig_d = ir_d[3:0];
    end
  end

  assign rom_addr   = pc_q;
  assign dbus       = drive_q ? imm_q : 8'hzz;
  assign assertBarA = bar_a_q;
  assign assertBarX = bar_x_q;
  assign triggerA   = trig_q[0];
  assign triggerB   = trig_q[1];
  assign triggerX   = trig_q[2];
  assign triggerQ   = trig_q[3];
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: ROM and register bank modelled here, outputs checked every cycle
// against an instruction-level reference model.
module tb_bus_sequencer;

  localparam logic [7:0] RP = 8'h00;

  logic       clk = 1'b0;
  logic       resetBar;
  logic       run;
  logic [7:0] rom_data;
  logic [7:0] rom_addr;
  wire  [7:0] dbus;
  logic       assertBarA, assertBarX;
  logic       triggerA, triggerB, triggerX, triggerQ;
  logic       halted;

  logic [7:0] rom [256];
  logic [7:0] areg, breg, xreg, qreg;
  logic [7:0] ZZ;
  int         n_vec = 0;
  int         n_err = 0;

  bus_sequencer #(.RESET_PC(RP)) dut (
    .clk        (clk),
    .resetBar   (resetBar),
    .run        (run),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .dbus       (dbus),
    .assertBarA (assertBarA),
    .assertBarX (assertBarX),
    .triggerA   (triggerA),
    .triggerB   (triggerB),
    .triggerX   (triggerX),
    .triggerQ   (triggerQ),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];
  assign dbus = !assertBarA ? areg : (!assertBarX ? xreg : 8'hzz);

  always @(posedge triggerA or negedge resetBar) if (!resetBar) areg <= 8'h00; else areg <= dbus;
  always @(posedge triggerB or negedge resetBar) if (!resetBar) breg <= 8'h00; else breg <= dbus;
  always @(posedge triggerX or negedge resetBar) if (!resetBar) xreg <= 8'h00; else xreg <= dbus;
  always @(posedge triggerQ or negedge resetBar) if (!resetBar) qreg <= 8'h00; else qreg <= dbus;

  // One expected cycle: pc seen on rom_addr, strobes, bus value and halted flag.
  typedef struct {
    logic [7:0] pc;
    logic       a_n;
    logic       x_n;
    logic       drv;
    logic [7:0] val;
    logic [3:0] trig;
    logic       hlt;
  } cyc_t;

  cyc_t       q[$];
  logic [7:0] mpc;
  logic       mhalt;
  logic [7:0] mreg [4];

  task automatic model_reset();
    q.delete();
    mpc   = RP;
    mhalt = 1'b0;
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
  endtask

  // Expand the instruction at mpc into its expected cycles.
  task automatic expand();
    cyc_t       r;
    logic [7:0] op, p1, p2, v;
    r = '{pc: mpc, a_n: 1'b1, x_n: 1'b1, drv: 1'b0, val: 8'h00, trig: 4'h0, hlt: mhalt};
    q.push_back(r);
    if (mhalt || !run) return;
    op = rom[mpc];
    p1 = mpc + 8'd1;
    p2 = p1 + 8'd1;
    case (op[7:6])
      2'b00: begin
        if (op[5:4] == 2'd0 || op[5:4] == 2'd1) begin
          v = op[4] ? mreg[2] : mreg[0];
          r.pc = p1; r.a_n = op[4]; r.x_n = !op[4]; r.drv = 1'b1; r.val = v;
          q.push_back(r);
          r.trig = op[3:0];
          q.push_back(r);
          mpc = p1;
        end else if (op[5:4] == 2'd2) begin
          r.pc = p1;
          q.push_back(r);
          r.pc = p2; r.drv = 1'b1; r.val = rom[p1];
          q.push_back(r);
          r.trig = op[3:0];
          q.push_back(r);
          mpc = p2;
        end else begin
          mpc = p1;
        end
      end
      2'b01: begin
        r.pc = p1;
        q.push_back(r);
        mpc = rom[p1];
      end
      2'b10: mpc = p1;
      default: begin
        mpc   = p1;
        mhalt = 1'b1;
      end
    endcase
  endtask

  // Compare n consecutive cycles against the model; called and returns at a falling edge.
  task automatic lockstep(input int n, input string tag);
    cyc_t       r;
    logic [7:0] expd;
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) expand();
      r = q.pop_front();
      for (int b = 0; b < 4; b++) if (r.trig[b]) mreg[b] = r.val;
      expd = r.drv ? r.val : ZZ;
      n_vec++;
      if (rom_addr !== r.pc) begin
        n_err++; $display("FAIL %s pc cyc%0d: got %h want %h", tag, i, rom_addr, r.pc);
      end
      n_vec++;
      if (assertBarA !== r.a_n) begin
        n_err++; $display("FAIL %s assertBarA cyc%0d: got %b want %b", tag, i, assertBarA, r.a_n);
      end
      n_vec++;
      if (assertBarX !== r.x_n) begin
        n_err++; $display("FAIL %s assertBarX cyc%0d: got %b want %b", tag, i, assertBarX, r.x_n);
      end
      n_vec++;
      if ({triggerQ, triggerX, triggerB, triggerA} !== r.trig) begin
        n_err++; $display("FAIL %s triggers QXBA cyc%0d: got %b want %b", tag, i,
                          {triggerQ, triggerX, triggerB, triggerA}, r.trig);
      end
      n_vec++;
      if (halted !== r.hlt) begin
        n_err++; $display("FAIL %s halted cyc%0d: got %b want %b", tag, i, halted, r.hlt);
      end
      n_vec++;
      if (dbus !== expd) begin
        n_err++; $display("FAIL %s dbus cyc%0d: got %h want %h", tag, i, dbus, expd);
      end
      n_vec++;
      if ({qreg, xreg, breg, areg} !== {mreg[3], mreg[2], mreg[1], mreg[0]}) begin
        n_err++; $display("FAIL %s bank QXBA cyc%0d: got %h want %h", tag, i,
                          {qreg, xreg, breg, areg}, {mreg[3], mreg[2], mreg[1], mreg[0]});
      end
      @(negedge clk);
    end
  endtask

  task automatic start(input logic run_v);
    run      = run_v;
    resetBar = 1'b1;
    model_reset();
  endtask

  task automatic load_rom(input logic [7:0] fill);
    resetBar = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) rom[i] = fill;
  endtask

  task automatic test_reset();
    resetBar = 1'b0;
    #1;
    n_vec++;
    if (rom_addr !== RP) begin n_err++; $display("FAIL reset pc: got %h want %h", rom_addr, RP); end
    n_vec++;
    if ({assertBarA, assertBarX} !== 2'b11) begin
      n_err++; $display("FAIL reset assertBars: got %b want 11", {assertBarA, assertBarX});
    end
    n_vec++;
    if ({triggerQ, triggerX, triggerB, triggerA} !== 4'b0000) begin
      n_err++; $display("FAIL reset triggers: got %b want 0000", {triggerQ, triggerX, triggerB, triggerA});
    end
    n_vec++;
    if (halted !== 1'b0) begin n_err++; $display("FAIL reset halted: got %b want 0", halted); end
    n_vec++;
    if (dbus !== ZZ) begin n_err++; $display("FAIL reset dbus: got %h want %h", dbus, ZZ); end
  endtask

  task automatic test_mov_imm();
    load_rom(8'h80);
    rom[0] = 8'h21; rom[1] = 8'h5A;
    start(1'b1);
    lockstep(4, "mov_imm");
    n_vec++;
    if (rom_addr !== 8'h02) begin n_err++; $display("FAIL mov_imm pc4: got %h want 02", rom_addr); end
    n_vec++;
    if (areg !== 8'h5A) begin n_err++; $display("FAIL mov_imm areg: got %h want 5a", areg); end
  endtask

  task automatic test_mov_reg();
    load_rom(8'h80);
    rom[0] = 8'h21; rom[1] = 8'h3C; rom[2] = 8'h0E; rom[3] = 8'hC0;
    start(1'b1);
    lockstep(12, "mov_reg");
    n_vec++;
    if ({breg, xreg, qreg} !== 24'h3C3C3C) begin
      n_err++; $display("FAIL mov_reg BXQ: got %h want 3c3c3c", {breg, xreg, qreg});
    end
  endtask

  task automatic test_jmp_halt();
    load_rom(8'h80);
    rom[0] = 8'h40; rom[1] = 8'hFE; rom[8'hFE] = 8'h80; rom[8'hFF] = 8'hC0;
    start(1'b1);
    lockstep(24, "jmp_halt");
    n_vec++;
    if (halted !== 1'b1) begin n_err++; $display("FAIL jmp_halt halted: got %b want 1", halted); end
    n_vec++;
    if (rom_addr !== 8'h00) begin n_err++; $display("FAIL jmp_halt pc: got %h want 00", rom_addr); end
  endtask

  task automatic test_run_stall();
    load_rom(8'h80);
    start(1'b0);
    lockstep(10, "stall");
    n_vec++;
    if (rom_addr !== 8'h00) begin n_err++; $display("FAIL stall pc: got %h want 00", rom_addr); end
    run = 1'b1;
    lockstep(6, "stall_go");
    n_vec++;
    if (rom_addr !== 8'h06) begin n_err++; $display("FAIL stall_go pc: got %h want 06", rom_addr); end
  endtask

  task automatic test_reset_mid_latch();
    load_rom(8'h80);
    rom[0] = 8'h28; rom[1] = 8'h77;
    start(1'b1);
    lockstep(3, "rst_latch");
    n_vec++;
    if (triggerQ !== 1'b1 || qreg !== 8'h77) begin
      n_err++; $display("FAIL rst_latch pre trigQ/qreg: got %b/%h want 1/77", triggerQ, qreg);
    end
    resetBar = 1'b0;
    #1;
    n_vec++;
    if (triggerQ !== 1'b0) begin n_err++; $display("FAIL rst_latch trigQ: got %b want 0", triggerQ); end
    n_vec++;
    if (dbus !== ZZ) begin n_err++; $display("FAIL rst_latch dbus: got %h want %h", dbus, ZZ); end
    n_vec++;
    if (rom_addr !== RP) begin n_err++; $display("FAIL rst_latch pc: got %h want %h", rom_addr, RP); end
    n_vec++;
    if (qreg !== 8'h00) begin n_err++; $display("FAIL rst_latch qreg: got %h want 00", qreg); end
    #1;
    start(1'b1);
    lockstep(6, "rst_restart");
  endtask

  task automatic test_reserved_mask0();
    load_rom(8'h80);
    rom[0] = 8'h21; rom[1] = 8'h5A; rom[2] = 8'h30; rom[3] = 8'h00; rom[4] = 8'hC0;
    start(1'b1);
    lockstep(12, "resv_mask0");
    n_vec++;
    if ({qreg, xreg, breg, areg} !== 32'h0000005A) begin
      n_err++; $display("FAIL resv_mask0 bank: got %h want 0000005a", {qreg, xreg, breg, areg});
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int round = 0; round < 4; round++) begin
      load_rom(8'h80);
      for (int i = 0; i < 256; i++) begin
        b = 8'($urandom);
        if (b[7:6] == 2'b11 && $urandom_range(0, 7) != 0) b[7] = 1'b0;
        rom[i] = b;
      end
      start(1'b1);
      for (int c = 0; c < 250; c++) begin
        run = ($urandom_range(0, 3) != 0);
        lockstep(1, "random");
      end
    end
  endtask

  initial begin
    ZZ       = 8'hzz;
    resetBar = 1'b0;
    run      = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h80;
    @(negedge clk);
    test_reset();
    test_mov_imm();
    test_mov_reg();
    test_jmp_halt();
    test_run_stall();
    test_reset_mid_latch();
    test_reserved_mask0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
